register_file_scoreboard: RTL and testbench

//  Parametrised successor to the core's GPR + HI/LO register file. Adds synchronous reset, same-cycle

---
 rtl/register_file_scoreboard.sv | 119 +++++++++++
 tb/tb_register_file_scoreboard.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_scoreboard.sv
// GPR + HI/LO register file with same-cycle write bypass and a per-register
// pending-write counter so decode can detect RAW hazards before issuing.
module register_file_scoreboard #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int PENDING_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    input  logic                  HI_LO_output,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  busy_1,
    output logic                  busy_2,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  hi_lo_register_write_enable,
    input  logic [DATA_WIDTH-1:0] HI_write_data,
    input  logic [DATA_WIDTH-1:0] LO_write_data,
    input  logic                  reserve_enable,
    input  logic [ADDR_WIDTH-1:0] reserve_address,
    input  logic                  reserve_hi_lo,
    output logic                  reserve_ready
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [PENDING_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0]    regs_q [NREGS];
    logic [DATA_WIDTH-1:0]    hi_q, lo_q;
    logic [PENDING_WIDTH-1:0] cnt_q  [NREGS];
    logic [PENDING_WIDTH-1:0] cnt_d  [NREGS];
    logic [PENDING_WIDTH-1:0] cnt_hl_q, cnt_hl_d;

    logic gpr_wr;
    logic dec1, dec2, dec_hl;
    logic gpr_ok, hl_ok;
    logic res_gpr_acc, res_hl_acc;

    assign gpr_wr = write_enable && (write_address != '0);
    assign dec1   = gpr_wr && (write_address == read_address_1) && (cnt_q[read_address_1] != '0);
    assign dec2   = gpr_wr && (write_address == read_address_2) && (cnt_q[read_address_2] != '0);
    assign dec_hl = hi_lo_register_write_enable && (cnt_hl_q != '0);

    // A full counter can still accept a reserve if it is being released this cycle.
    assign gpr_ok = !reserve_enable || (reserve_address == '0) ||
                    (cnt_q[reserve_address] != CNT_MAX) ||
                    (gpr_wr && (write_address == reserve_address));
    assign hl_ok  = !reserve_hi_lo || (cnt_hl_q != CNT_MAX) || hi_lo_register_write_enable;
    assign reserve_ready = gpr_ok && hl_ok;

    assign res_gpr_acc = reserve_enable && reserve_ready && (reserve_address != '0);
    assign res_hl_acc  = reserve_hi_lo && reserve_ready;

    always_comb begin
        read_data_1 = '0;
        read_data_2 = '0;
        busy_1      = 1'b0;
        busy_2      = 1'b0;
        if (HI_LO_output) begin
            read_data_1 = hi_lo_register_write_enable ? LO_write_data : lo_q;
            read_data_2 = hi_lo_register_write_enable ? HI_write_data : hi_q;
            busy_1      = (cnt_hl_q - PENDING_WIDTH'(dec_hl)) != '0;
            busy_2      = busy_1;
        end else begin
            if (read_address_1 != '0)
                read_data_1 = (gpr_wr && write_address == read_address_1) ? write_data
                                                                           : regs_q[read_address_1];
            if (read_address_2 != '0)
                read_data_2 = (gpr_wr && write_address == read_address_2) ? write_data
                                                                           : regs_q[read_address_2];
            busy_1 = (cnt_q[read_address_1] - PENDING_WIDTH'(dec1)) != '0;
            busy_2 = (cnt_q[read_address_2] - PENDING_WIDTH'(dec2)) != '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            logic inc, dec;
            inc      = res_gpr_acc && (reserve_address == ADDR_WIDTH'(i));
            dec      = gpr_wr && (write_address == ADDR_WIDTH'(i)) && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc && !dec)
                cnt_d[i] = cnt_q[i] + 1'b1;
            else if (dec && !inc)
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
        cnt_hl_d = cnt_hl_q;
        if (res_hl_acc && !dec_hl)
            cnt_hl_d = cnt_hl_q + 1'b1;
        else if (dec_hl && !res_hl_acc)
            cnt_hl_d = cnt_hl_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_hl_q <= '0;
        end else begin
            if (gpr_wr)
                regs_q[write_address] <= write_data;
            if (hi_lo_register_write_enable) begin
                hi_q <= HI_write_data;
                lo_q <= LO_write_data;
            end
            cnt_q    <= cnt_d;
            cnt_hl_q <= cnt_hl_d;
        end
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: a behavioural model pushes expected outputs
// each cycle, popped and compared mid-cycle; directed cases add literal checks.
module tb_register_file_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_address_1, read_address_2;
    logic        HI_LO_output;
    logic [31:0] read_data_1, read_data_2;
    logic        busy_1, busy_2;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        hi_lo_register_write_enable;
    logic [31:0] HI_write_data, LO_write_data;
    logic        reserve_enable;
    logic [4:0]  reserve_address;
    logic        reserve_hi_lo;
    logic        reserve_ready;

    register_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .PENDING_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .read_address_1(read_address_1), .read_address_2(read_address_2),
        .HI_LO_output(HI_LO_output),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .busy_1(busy_1), .busy_2(busy_2),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .hi_lo_register_write_enable(hi_lo_register_write_enable),
        .HI_write_data(HI_write_data), .LO_write_data(LO_write_data),
        .reserve_enable(reserve_enable), .reserve_address(reserve_address),
        .reserve_hi_lo(reserve_hi_lo), .reserve_ready(reserve_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic        rdy;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_hi, m_lo;
    int          m_cnt [32];
    int          m_cnthl;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic m_ready();
        logic g, h;
        g = !(reserve_enable && reserve_address != 0 && m_cnt[reserve_address] == 3 &&
              !(write_enable && write_address == reserve_address));
        h = !(reserve_hi_lo && m_cnthl == 3 && !hi_lo_register_write_enable);
        return g && h;
    endfunction

    function automatic logic [31:0] m_gpr_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (write_enable && write_address == a) return write_data;
        return m_regs[a];
    endfunction

    function automatic logic m_gpr_busy(input logic [4:0] a);
        int c;
        if (a == 0) return 1'b0;
        c = m_cnt[a];
        if (write_enable && write_address == a && c > 0) c--;
        return c > 0;
    endfunction

    function automatic exp_t m_outputs();
        exp_t e;
        int   c;
        if (HI_LO_output) begin
            e.d1 = hi_lo_register_write_enable ? LO_write_data : m_lo;
            e.d2 = hi_lo_register_write_enable ? HI_write_data : m_hi;
            c = m_cnthl;
            if (hi_lo_register_write_enable && c > 0) c--;
            e.b1 = c > 0;
            e.b2 = c > 0;
        end else begin
            e.d1 = m_gpr_read(read_address_1);
            e.d2 = m_gpr_read(read_address_2);
            e.b1 = m_gpr_busy(read_address_1);
            e.b2 = m_gpr_busy(read_address_2);
        end
        e.rdy = m_ready();
        return e;
    endfunction

    task automatic m_update();
        logic rdy;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_cnt[i]  = 0;
            end
            m_hi = 0; m_lo = 0; m_cnthl = 0;
            return;
        end
        rdy = m_ready();
        for (int r = 1; r < 32; r++) begin
            logic inc, dec;
            inc = reserve_enable && rdy && reserve_address == r;
            dec = write_enable && write_address == r && m_cnt[r] > 0;
            if (inc && !dec) m_cnt[r]++;
            if (dec && !inc) m_cnt[r]--;
        end
        begin
            logic inc, dec;
            inc = reserve_hi_lo && rdy;
            dec = hi_lo_register_write_enable && m_cnthl > 0;
            if (inc && !dec) m_cnthl++;
            if (dec && !inc) m_cnthl--;
        end
        if (write_enable && write_address != 0) m_regs[write_address] = write_data;
        if (hi_lo_register_write_enable) begin
            m_hi = HI_write_data;
            m_lo = LO_write_data;
        end
    endtask

    // Push the model's prediction, then sample the DUT at the falling edge.
    task automatic sample(input string tag);
        exp_t e, got;
        sb_q.push_back(m_outputs());
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'h1, 32'h0);
            return;
        end
        e   = sb_q.pop_front();
        got = '{read_data_1, read_data_2, busy_1, busy_2, reserve_ready};
        chk({tag, "_rd1"}, got.d1, e.d1);
        chk({tag, "_rd2"}, got.d2, e.d2);
        chk({tag, "_busy1"}, 32'(got.b1), 32'(e.b1));
        chk({tag, "_busy2"}, 32'(got.b2), 32'(e.b2));
        chk({tag, "_ready"}, 32'(got.rdy), 32'(e.rdy));
    endtask

    task automatic advance();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        reset = 0; HI_LO_output = 0;
        write_enable = 0; write_address = 0; write_data = 0;
        hi_lo_register_write_enable = 0; HI_write_data = 0; LO_write_data = 0;
        reserve_enable = 0; reserve_address = 0; reserve_hi_lo = 0;
    endtask

    initial begin
        idle();
        read_address_1 = 0; read_address_2 = 0;
        reset = 1;
        @(posedge clk);
        m_update();
        #1;
        idle();

        // 1: everything reads zero after reset; r0 ignores writes
        for (int a = 0; a < 32; a++) begin
            read_address_1 = 5'(a); read_address_2 = 5'(31 - a);
            sample("t1");
            chk("t1_rd1_zero", read_data_1, 32'h0);
            chk("t1_ready_one", 32'(reserve_ready), 32'h1);
            advance();
        end
        write_enable = 1; write_address = 0; write_data = 32'hDEADBEEF; read_address_1 = 0;
        sample("t1w"); advance(); idle();
        sample("t1r0"); chk("t1_r0_zero", read_data_1, 32'h0); advance();

        // 2: bypass then registered value
        write_enable = 1; write_address = 5; write_data = 32'h12345678; read_address_1 = 5;
        sample("t2a"); chk("t2_bypass", read_data_1, 32'h12345678); advance(); idle();
        sample("t2b"); chk("t2_stored", read_data_1, 32'h12345678); advance();

        // 3: reserve, busy, writeback clears busy in the same cycle
        reserve_enable = 1; reserve_address = 7; read_address_1 = 7;
        sample("t3c0"); advance(); idle();
        sample("t3c1"); chk("t3_busy_set", 32'(busy_1), 32'h1); advance();
        sample("t3c2"); advance();
        write_enable = 1; write_address = 7; write_data = 32'hA5;
        sample("t3c3"); chk("t3_busy_clr", 32'(busy_1), 32'h0);
        chk("t3_data", read_data_1, 32'hA5); advance(); idle();

        // 4: saturate r9 and drop the fourth reserve
        read_address_1 = 9;
        for (int k = 0; k < 4; k++) begin
            reserve_enable = 1; reserve_address = 9;
            sample("t4res");
            if (k == 3) chk("t4_ready_full", 32'(reserve_ready), 32'h0);
            advance();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            write_enable = 1; write_address = 9; write_data = 32'(k);
            sample("t4wb");
            chk("t4_busy_wb", 32'(busy_1), (k == 2) ? 32'h0 : 32'h1);
            advance();
        end
        idle();
        sample("t4end"); chk("t4_busy_end", 32'(busy_1), 32'h0); advance();

        // 5: HI/LO reserve and writeback
        reserve_hi_lo = 1; HI_LO_output = 1;
        sample("t5res"); advance(); idle(); HI_LO_output = 1;
        sample("t5busy"); chk("t5_busy_hl", 32'(busy_1), 32'h1); advance();
        hi_lo_register_write_enable = 1; HI_write_data = 32'h1; LO_write_data = 32'h2;
        sample("t5wb");
        chk("t5_hi", read_data_2, 32'h1); chk("t5_lo", read_data_1, 32'h2);
        chk("t5_busy_clr", 32'(busy_2), 32'h0);
        advance(); idle();

        // 6: reserve+release in one cycle keeps the count, then reset clears all
        reserve_enable = 1; reserve_address = 3; read_address_1 = 3;
        sample("t6a"); advance();
        write_enable = 1; write_address = 3; write_data = 32'h33;
        sample("t6b"); advance(); idle();
        sample("t6c"); chk("t6_still_busy", 32'(busy_1), 32'h1);
        chk("t6_data", read_data_1, 32'h33); advance();
        reset = 1; sample("t6rst"); advance(); idle();
        sample("t6post"); chk("t6_rst_data", read_data_1, 32'h0);
        chk("t6_rst_busy", 32'(busy_1), 32'h0); advance();

        // Random traffic over a few registers to stress counter interactions
        for (int n = 0; n < 300; n++) begin
            reset          = ($urandom_range(0, 99) == 0);
            read_address_1 = 5'($urandom_range(0, 4));
            read_address_2 = 5'($urandom_range(0, 4));
            HI_LO_output   = ($urandom_range(0, 5) == 0);
            write_enable   = $urandom_range(0, 1);
            write_address  = 5'($urandom_range(0, 4));
            write_data     = $urandom;
            hi_lo_register_write_enable = ($urandom_range(0, 3) == 0);
            HI_write_data  = $urandom;
            LO_write_data  = $urandom;
            reserve_enable = $urandom_range(0, 1);
            reserve_address = 5'($urandom_range(0, 4));
            reserve_hi_lo  = ($urandom_range(0, 2) == 0);
            sample("rnd");
            advance();
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
